// File: rtl/field_arbiter.sv
// field_arbiter: collision checker and playfield store for a falling-block game.
// A move request is checked block by block against the field; the arbiter answers
// with a commit pulse, a declined level, or a steal level. A steal also merges the
// piece into the field, one row above where it collided.
// Optional build macro FIELD_ARBITER_LINE_CLEAR_EN: when defined, full rows are
// cleared after each merge and counted on lines_cleared; otherwise full rows stay
// in place and lines_cleared is tied to zero.
module field_arbiter #(
  parameter int unsigned FIELD_W = 10,
  parameter int unsigned FIELD_H = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       movement_request,
  input  logic       movement_intent,
  input  logic [4:0] P1blk_v,
  input  logic [4:0] P2blk_v,
  input  logic [4:0] P3blk_v,
  input  logic [4:0] P4blk_v,
  input  logic [4:0] P1blk_h,
  input  logic [4:0] P2blk_h,
  input  logic [4:0] P3blk_h,
  input  logic [4:0] P4blk_h,
  input  logic [2:0] volatile_blk_color,
  output logic       movement_commit,
  output logic       movement_declined,
  output logic       movement_steal,
  input  logic [4:0] rd_v,
  input  logic [4:0] rd_h,
  output logic [2:0] rd_color,
  output logic [7:0] lines_cleared
);

  localparam int unsigned CW = (FIELD_W > 1) ? $clog2(FIELD_W) : 1;
  localparam int unsigned RW = (FIELD_H > 1) ? $clog2(FIELD_H) : 1;
  localparam logic [4:0] W_LIM = 5'(FIELD_W);
  localparam logic [4:0] H_LIM = 5'(FIELD_H);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    COMMIT,
    DECLINE,
    MERGE,
    CLEAR,
    STEAL_HOLD
  } state_t;

  state_t state;

  // One packed row of 3-bit cells per playfield row; 0 means empty.
  logic [FIELD_W-1:0][2:0] field [FIELD_H];

  logic [4:0] lat_v [4];
  logic [4:0] lat_h [4];
  logic       lat_intent;
  logic [2:0] lat_color;
  logic [1:0] idx;
  logic       coll_acc;

  logic [4:0] cur_v;
  logic [4:0] cur_h;
  logic [4:0] mrg_h;
  logic       cur_in;
  logic       cur_hit;
  logic       mrg_ok;
  logic [2:0] cur_cell;

  // Collision and merge-target evaluation for the block selected by idx.
  always_comb begin
    cur_v    = lat_v[idx];
    cur_h    = lat_h[idx];
    cur_in   = (cur_v < W_LIM) && (cur_h < H_LIM);
    cur_cell = cur_in ? field[RW'(cur_h)][CW'(cur_v)] : '0;
    cur_hit  = !cur_in || (cur_cell != '0);
    mrg_h    = cur_h - 5'd1;
    mrg_ok   = (cur_h != '0) && (cur_v < W_LIM) && (mrg_h < H_LIM);
  end

  // Renderer read port; anything outside the field reads as empty.
  always_comb begin
    rd_color = '0;
    if ((rd_v < W_LIM) && (rd_h < H_LIM))
      rd_color = field[RW'(rd_h)][CW'(rd_v)];
  end

`ifdef FIELD_ARBITER_LINE_CLEAR_EN
  logic [4:0] clr_row;
  logic [7:0] lines_q;
  logic       row_full;

  // A row is full when every cell in it is occupied.
  always_comb begin
    row_full = 1'b1;
    for (int unsigned c = 0; c < FIELD_W; c++)
      if (field[RW'(clr_row)][CW'(c)] == '0)
        row_full = 1'b0;
  end

  assign lines_cleared = lines_q;
`else
  assign lines_cleared = '0;
`endif

  // Arbiter sequencing, field updates and registered responses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      movement_commit   <= 1'b0;
      movement_declined <= 1'b0;
      movement_steal    <= 1'b0;
      for (int unsigned r = 0; r < FIELD_H; r++)
        field[RW'(r)] <= '0;
      for (int unsigned b = 0; b < 4; b++) begin
        lat_v[2'(b)] <= '0;
        lat_h[2'(b)] <= '0;
      end
      lat_intent <= 1'b0;
      lat_color  <= '0;
      idx        <= '0;
      coll_acc   <= 1'b0;
`ifdef FIELD_ARBITER_LINE_CLEAR_EN
      clr_row    <= '0;
      lines_q    <= '0;
`endif
    end else begin
      movement_commit <= 1'b0;
      case (state)
        IDLE: begin
          if (movement_request) begin
            lat_v[0]   <= P1blk_v;
            lat_v[1]   <= P2blk_v;
            lat_v[2]   <= P3blk_v;
            lat_v[3]   <= P4blk_v;
            lat_h[0]   <= P1blk_h;
            lat_h[1]   <= P2blk_h;
            lat_h[2]   <= P3blk_h;
            lat_h[3]   <= P4blk_h;
            lat_intent <= movement_intent;
            lat_color  <= volatile_blk_color;
            idx        <= '0;
            coll_acc   <= 1'b0;
            state      <= CHECK;
          end
        end
        CHECK: begin
          if (!movement_request) begin
            state <= IDLE;
          end else if (idx == 2'd3) begin
            // Final block folds its own hit in directly instead of via coll_acc.
            if (coll_acc || cur_hit) begin
              if (lat_intent) begin
                movement_declined <= 1'b1;
                state             <= DECLINE;
              end else begin
                movement_steal <= 1'b1;
                idx            <= '0;
                state          <= MERGE;
              end
            end else begin
              state <= COMMIT;
            end
          end else begin
            coll_acc <= coll_acc || cur_hit;
            idx      <= idx + 2'd1;
          end
        end
        COMMIT: begin
          movement_commit <= 1'b1;
          state           <= IDLE;
        end
        DECLINE: begin
          if (!movement_request) begin
            movement_declined <= 1'b0;
            state             <= IDLE;
          end
        end
        MERGE: begin
          if (mrg_ok)
            field[RW'(mrg_h)][CW'(cur_v)] <= lat_color;
          if (idx == 2'd3) begin
`ifdef FIELD_ARBITER_LINE_CLEAR_EN
            clr_row <= H_LIM - 5'd1;
            state   <= CLEAR;
`else
            state   <= STEAL_HOLD;
`endif
          end else begin
            idx <= idx + 2'd1;
          end
        end
        CLEAR: begin
`ifdef FIELD_ARBITER_LINE_CLEAR_EN
          // A cleared row is rescanned, since the row above has dropped into it.
          if (row_full) begin
            for (int unsigned i = 1; i < FIELD_H; i++)
              if (i <= 32'(clr_row))
                field[RW'(i)] <= field[RW'(i - 1)];
            field[0] <= '0;
            lines_q  <= lines_q + 8'd1;
          end else if (clr_row == '0) begin
            state <= STEAL_HOLD;
          end else begin
            clr_row <= clr_row - 5'd1;
          end
`else
          state <= STEAL_HOLD;
`endif
        end
        STEAL_HOLD: begin
          if (!movement_request) begin
            movement_steal <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_field_arbiter.sv
// tb_field_arbiter: directed and randomized moves against a cell-array model of
// the playfield (collide / land / drop full rows).
module tb_field_arbiter;

  localparam int W = 10;
  localparam int H = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       movement_request;
  logic       movement_intent;
  logic [4:0] pv [4];
  logic [4:0] ph [4];
  logic [2:0] volatile_blk_color;
  logic       movement_commit;
  logic       movement_declined;
  logic       movement_steal;
  logic [4:0] rd_v;
  logic [4:0] rd_h;
  logic [2:0] rd_color;
  logic [7:0] lines_cleared;

  int n_tests = 0;
  int n_fail  = 0;

  int model [H][W];
  int exp_lines;
  int bv [4];
  int bh [4];

  field_arbiter #(.FIELD_W(W), .FIELD_H(H)) dut (
    .clk(clk),
    .reset(reset),
    .movement_request(movement_request),
    .movement_intent(movement_intent),
    .P1blk_v(pv[0]),
    .P2blk_v(pv[1]),
    .P3blk_v(pv[2]),
    .P4blk_v(pv[3]),
    .P1blk_h(ph[0]),
    .P2blk_h(ph[1]),
    .P3blk_h(ph[2]),
    .P4blk_h(ph[3]),
    .volatile_blk_color(volatile_blk_color),
    .movement_commit(movement_commit),
    .movement_declined(movement_declined),
    .movement_steal(movement_steal),
    .rd_v(rd_v),
    .rd_h(rd_h),
    .rd_color(rd_color),
    .lines_cleared(lines_cleared)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_blocks(input int v0, v1, v2, v3, input int h0, h1, h2, h3);
    bv[0] = v0; bv[1] = v1; bv[2] = v2; bv[3] = v3;
    bh[0] = h0; bh[1] = h1; bh[2] = h2; bh[3] = h3;
  endtask

  function automatic bit model_collides();
    for (int b = 0; b < 4; b++) begin
      if (bv[b] >= W || bh[b] >= H) return 1'b1;
      if (model[bh[b]][bv[b]] != 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Land the piece one row above its proposed spot, then drop any full rows.
  task automatic model_land(input int color);
    int tmp [H][W];
    int dst;
    int cleared;
    bit full;
    for (int b = 0; b < 4; b++)
      if (bh[b] != 0 && bv[b] < W && bh[b] - 1 < H)
        model[bh[b] - 1][bv[b]] = color;
`ifdef FIELD_ARBITER_LINE_CLEAR_EN
    dst = H - 1;
    cleared = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        tmp[r][c] = 0;
    for (int r = H - 1; r >= 0; r--) begin
      full = 1'b1;
      for (int c = 0; c < W; c++)
        if (model[r][c] == 0) full = 1'b0;
      if (full) cleared++;
      else begin
        for (int c = 0; c < W; c++) tmp[dst][c] = model[r][c];
        dst--;
      end
    end
    model = tmp;
    exp_lines = (exp_lines + cleared) % 256;
`endif
  endtask

  task automatic model_reset();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        model[r][c] = 0;
    exp_lines = 0;
  endtask

  task automatic compare_field();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        rd_v = 5'(c);
        rd_h = 5'(r);
        #1;
        check_eq($sformatf("cell_v%0d_h%0d", c, r), int'(rd_color), model[r][c]);
      end
    rd_v = 5'd10; rd_h = 5'd19; #1;
    check_eq("rd_oor_v", int'(rd_color), 0);
    rd_v = 5'd3;  rd_h = 5'd20; #1;
    check_eq("rd_oor_h", int'(rd_color), 0);
    rd_v = 5'd31; rd_h = 5'd31; #1;
    check_eq("rd_oor_vh", int'(rd_color), 0);
  endtask

  function automatic int resp_kind();
    if (movement_commit)   return 1;
    if (movement_declined) return 2;
    if (movement_steal)    return 3;
    return 0;
  endfunction

  task automatic drive_request(input bit intent, input int color);
    for (int b = 0; b < 4; b++) begin
      pv[b] = 5'(bv[b]);
      ph[b] = 5'(bh[b]);
    end
    movement_intent    = intent;
    volatile_blk_color = 3'(color);
    movement_request   = 1'b1;
  endtask

  // Kinds: 1 commit, 2 declined, 3 steal.
  task automatic run_move(input bit intent, input int color, input int hold, input bit cmp);
    int exp_kind;
    int got_kind;
    int n;
    exp_kind = model_collides() ? (intent ? 2 : 3) : 1;
    drive_request(intent, color);
    tick();
    got_kind = 0;
    n = 0;
    while (got_kind == 0 && n < 40) begin
      tick();
      n++;
      check_eq("exclusive",
               ($countones({movement_commit, movement_declined, movement_steal}) <= 1) ? 1 : 0, 1);
      got_kind = resp_kind();
    end
    check_eq("resp_kind", got_kind, exp_kind);
    check_eq("resp_latency", n, (exp_kind == 1) ? 5 : 4);
    case (got_kind)
      1: begin
        movement_request = 1'b0;
        tick();
        check_eq("commit_pulse", int'(movement_commit), 0);
      end
      2: begin
        repeat (hold) begin
          tick();
          check_eq("declined_hold", int'(movement_declined), 1);
        end
        movement_request = 1'b0;
        tick();
        check_eq("declined_release", int'(movement_declined), 0);
      end
      3: begin
        repeat (40) tick();
        check_eq("steal_hold", int'(movement_steal), 1);
        movement_request = 1'b0;
        tick();
        check_eq("steal_release", int'(movement_steal), 0);
      end
      default: begin
        movement_request = 1'b0;
        repeat (45) tick();
      end
    endcase
    if (exp_kind == 3) model_land(color);
    tick();
    check_eq("lines_cleared", int'(lines_cleared), exp_lines);
    if (cmp) compare_field();
  endtask

  task automatic run_abort(input bit intent, input int color, input int k);
    int busy;
    drive_request(intent, color);
    tick();
    repeat (k) tick();
    movement_request = 1'b0;
    busy = 0;
    repeat (8) begin
      tick();
      busy = busy | resp_kind();
    end
    check_eq("abort_quiet", busy, 0);
    compare_field();
  endtask

  initial begin
    int sv;
    int sh;
    int shp;
    int dv;
    int dh;
    int bvv [4];
    int bhh [4];

    reset = 1'b0;
    movement_request = 1'b0;
    movement_intent = 1'b0;
    volatile_blk_color = '0;
    rd_v = '0;
    rd_h = '0;
    for (int b = 0; b < 4; b++) begin
      pv[b] = '0;
      ph[b] = '0;
    end
    model_reset();
    repeat (3) tick();
    check_eq("rst_commit", int'(movement_commit), 0);
    check_eq("rst_declined", int'(movement_declined), 0);
    check_eq("rst_steal", int'(movement_steal), 0);
    check_eq("rst_lines", int'(lines_cleared), 0);
    reset = 1'b1;
    tick();
    compare_field();

    // Gravity move into empty space commits.
    set_blocks(5, 6, 7, 8, 6, 6, 6, 6);
    run_move(1'b0, 3, 0, 1'b1);

    // Player move off the right edge is declined.
    set_blocks(10, 1, 2, 3, 2, 2, 2, 2);
    run_move(1'b1, 2, 3, 1'b1);

    // Landing through the floor: row 19 v0..3, then v4..7, then v8.
    set_blocks(0, 1, 2, 3, 20, 20, 20, 20);
    run_move(1'b0, 5, 0, 1'b1);
    rd_v = 5'd0; rd_h = 5'd19; #1;
    check_eq("land_floor_color", int'(rd_color), 5);
    set_blocks(4, 5, 6, 7, 20, 20, 20, 20);
    run_move(1'b0, 1, 0, 1'b0);
    set_blocks(8, 8, 8, 8, 20, 20, 20, 20);
    run_move(1'b0, 2, 0, 1'b0);
    // Stack on top of occupied cells: lands in row 18.
    set_blocks(0, 1, 0, 1, 19, 19, 19, 19);
    run_move(1'b0, 6, 0, 1'b1);
    // Complete row 19.
    set_blocks(9, 9, 9, 9, 20, 20, 20, 20);
    run_move(1'b0, 4, 0, 1'b1);
    rd_v = 5'd9; rd_h = 5'd19; #1;
`ifdef FIELD_ARBITER_LINE_CLEAR_EN
    check_eq("clear_lines_const", int'(lines_cleared), 1);
    check_eq("clear_row19_v9", int'(rd_color), 0);
    rd_v = 5'd0; #1;
    check_eq("clear_shift_v0", int'(rd_color), 6);
`else
    check_eq("clear_lines_const", int'(lines_cleared), 0);
    check_eq("clear_row19_v9", int'(rd_color), 4);
    rd_v = 5'd0; #1;
    check_eq("clear_shift_v0", int'(rd_color), 5);
`endif

    // Reset while the merged piece is being processed.
    set_blocks(3, 4, 5, 6, 20, 20, 20, 20);
    drive_request(1'b0, 7);
    tick();
    begin
      int n;
      n = 0;
      while (!movement_steal && n < 40) begin
        tick();
        n++;
      end
      check_eq("rst_mid_steal_seen", int'(movement_steal), 1);
    end
    repeat (6) tick();
    reset = 1'b0;
    movement_request = 1'b0;
    #1;
    check_eq("rst_mid_commit", int'(movement_commit), 0);
    check_eq("rst_mid_declined", int'(movement_declined), 0);
    check_eq("rst_mid_steal", int'(movement_steal), 0);
    check_eq("rst_mid_lines", int'(lines_cleared), 0);
    model_reset();
    compare_field();
    tick();
    reset = 1'b1;
    tick();
    set_blocks(5, 6, 7, 8, 6, 6, 6, 6);
    run_move(1'b0, 3, 0, 1'b1);

    // Randomized pieces.
    for (int it = 0; it < 40; it++) begin
      sv  = $urandom_range(0, 10);
      sh  = $urandom_range(0, 21);
      shp = $urandom_range(0, 3);
      for (int b = 0; b < 4; b++) begin
        case (shp)
          0: begin dv = b;     dh = 0;     end
          1: begin dv = 0;     dh = b;     end
          2: begin dv = b % 2; dh = b / 2; end
          default: begin dv = (b < 3) ? 0 : 1; dh = (b < 3) ? b : 2; end
        endcase
        bvv[b] = sv + dv;
        bhh[b] = sh + dh;
      end
      set_blocks(bvv[0], bvv[1], bvv[2], bvv[3], bhh[0], bhh[1], bhh[2], bhh[3]);
      if ($urandom_range(0, 6) == 0)
        run_abort(1'($urandom_range(0, 1)), $urandom_range(1, 7), $urandom_range(0, 3));
      else
        run_move(1'($urandom_range(0, 1)), $urandom_range(1, 7), $urandom_range(0, 3), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/field_arbiter.md
FIELD_ARBITER -- requirements
Module: field_arbiter

Interface
REQ-001 SHALL have parameter FIELD_W, default 10, playfield columns (v axis).
REQ-002 SHALL have parameter FIELD_H, default 20, playfield rows (h axis, h grows downward).
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low; clears all state.
REQ-005 SHALL have port movement_request  input  1  volatile piece requests a move check.
REQ-006 SHALL have port movement_intent  input  1  0 = gravity move, 1 = player move or rotate.
REQ-007 SHALL have ports P1blk_v..P4blk_v and P1blk_h..P4blk_h  input  5 each  proposed block coordinates.
REQ-008 SHALL have port volatile_blk_color  input  3  colour of the falling piece; 0 is never used.
REQ-009 SHALL have port movement_commit  output  1  one-cycle pulse: move accepted.
REQ-010 SHALL have port movement_declined  output  1  level: move rejected.
REQ-011 SHALL have port movement_steal  output  1  level: piece landed and merged into the field.
REQ-012 SHALL have ports rd_v, rd_h  input  5 each  and rd_color  output  3  combinational renderer read port.
REQ-013 SHALL have port lines_cleared  output  8  count of cleared rows.

Function
REQ-014 Field: FIELD_H x FIELD_W cells of 3 bits; 0 = empty.
REQ-015 rd_color = cell(rd_v, rd_h); 0 if rd_v >= FIELD_W or rd_h >= FIELD_H.
REQ-016 States: IDLE, CHECK, COMMIT, DECLINE, MERGE, CLEAR, STEAL_HOLD.
REQ-017 IDLE: on movement_request = 1, latch all 8 coordinates, intent and colour; go to CHECK.
REQ-018 CHECK: 4 cycles; check one block per cycle, P1 first.
REQ-019 Collision per block: v >= FIELD_W, h >= FIELD_H, or cell nonzero; collisions OR-accumulate.
REQ-020 No collision after 4 checks: go to COMMIT; assert movement_commit for exactly one cycle; then IDLE.
REQ-021 Collision with intent = 1: go to DECLINE; hold movement_declined high until movement_request is sampled low; clear it the next cycle; then IDLE.
REQ-022 Collision with intent = 0: assert movement_steal; go to MERGE.
REQ-023 MERGE: 4 cycles; write the latched colour to cell (v, h-1) for each block, P1 first.
REQ-024 MERGE: skip the write for any block with h = 0 or out-of-range v/h-1.
REQ-025 CLEAR: scan one row per cycle from FIELD_H-1 toward 0.
REQ-026 CLEAR, full row: shift all rows above it down by one and zero row 0 in that cycle; increment lines_cleared (wraps 255 -> 0); rescan the same row.
REQ-027 CLEAR, row not full: move up one row; after row 0 go to STEAL_HOLD.
REQ-028 STEAL_HOLD: hold movement_steal high until movement_request is sampled low; clear it the next cycle; then IDLE.
REQ-029 movement_request falling during CHECK: abort to IDLE; no response, field unchanged.
REQ-030 Commit, declined and steal are mutually exclusive; at most one is high in any cycle.
REQ-031 A new request is accepted only in IDLE.

Reset
REQ-032 reset low: state = IDLE; commit, declined, steal = 0; all cells = 0; lines_cleared = 0; latches = 0.
REQ-033 reset asserted mid-operation (including MERGE/CLEAR): abandon the operation immediately; no partial behaviour persists after release.

Configuration
REQ-034 Macro FIELD_ARBITER_LINE_CLEAR_EN defined: CLEAR state and lines_cleared behave per REQ-025..027.
REQ-035 Macro FIELD_ARBITER_LINE_CLEAR_EN undefined: MERGE goes directly to STEAL_HOLD; lines_cleared tied to 0; full rows remain.

Verification
REQ-036 Empty field, request intent=0, blocks (5,6),(6,6),(7,6),(8,6) -> one commit pulse 5 cycles after the request is sampled; no declined or steal.
REQ-037 Request intent=1 with P1blk_v=10 -> declined high until the request drops, low one cycle later; field unchanged.
REQ-038 Request intent=0 with any block at h=20 -> steal; cells at h=19 take the latched colour; steal drops one cycle after the request goes low.
REQ-039 Row 19 holds 9 cells (v 0..8); land a piece filling v=9 at row 19 -> row 19 cleared, rows above shifted down, lines_cleared = 1 (LINE_CLEAR_EN).
REQ-040 Same as REQ-039 without the macro -> row 19 stays full; lines_cleared = 0.
REQ-041 Assert reset during CLEAR -> all outputs 0; rd_color = 0 everywhere; IDLE accepts the next request.
